// File: rtl/rotary_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rotary_decoder: quadrature encoder sync, debounce and detent decoder.     |
// | Optional illegal-transition strobe err_o under ROTARY_DECODER_ERR_EN.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module rotary_decoder #(
  parameter int CLOCK_FREQ_MHZ = 100,
  parameter int DELAY_IN_US    = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic a_i,
  input  logic b_i,
  output logic right_o,
  output logic left_o,
  output logic a_filt_o,
`ifdef ROTARY_DECODER_ERR_EN
  output logic b_filt_o,
  output logic err_o
`else
  output logic b_filt_o
`endif
);

  localparam int N  = CLOCK_FREQ_MHZ * DELAY_IN_US;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    R1   = 3'd1,
    R2   = 3'd2,
    R3   = 3'd3,
    L1   = 3'd4,
    L2   = 3'd5,
    L3   = 3'd6
  } state_t;

  // Bit 1 carries contact A, bit 0 carries contact B.
  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt_q;

  assign raw = {a_i, b_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_d;

    // Any cycle of agreement restarts the stability window.
    always_comb begin
      cnt_d  = '0;
      filt_d = filt_q[g];
      if (sync2_q[g] != filt_q[g]) begin
        if (cnt_q == C_CNT_MAX) begin
          filt_d = sync2_q[g];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q     <= '0;
        filt_q[g] <= 1'b1;
      end else begin
        cnt_q     <= cnt_d;
        filt_q[g] <= filt_d;
      end
    end
  end

  state_t state_q, state_d;
  logic   right_q, right_d;
  logic   left_q,  left_d;
  logic   bad;

  always_comb begin
    state_d = state_q;
    right_d = 1'b0;
    left_d  = 1'b0;
    bad     = 1'b0;
    unique case (state_q)
      IDLE: case (filt_q)
        2'b01:   state_d = R1;
        2'b10:   state_d = L1;
        2'b00:   bad = 1'b1;
        default: ;
      endcase
      R1: case (filt_q)
        2'b00:   state_d = R2;
        2'b11:   state_d = IDLE;
        default: ;
      endcase
      R2: case (filt_q)
        2'b10:   state_d = R3;
        2'b01:   state_d = R1;
        2'b11:   bad = 1'b1;
        default: ;
      endcase
      R3: case (filt_q)
        2'b11: begin
          state_d = IDLE;
          right_d = 1'b1;
        end
        2'b00:   state_d = R2;
        2'b01:   bad = 1'b1;
        default: ;
      endcase
      L1: case (filt_q)
        2'b00:   state_d = L2;
        2'b11:   state_d = IDLE;
        default: ;
      endcase
      L2: case (filt_q)
        2'b01:   state_d = L3;
        2'b10:   state_d = L1;
        2'b11:   bad = 1'b1;
        default: ;
      endcase
      L3: case (filt_q)
        2'b11: begin
          state_d = IDLE;
          left_d  = 1'b1;
        end
        2'b00:   state_d = L2;
        2'b10:   bad = 1'b1;
        default: ;
      endcase
      default: state_d = IDLE;
    endcase
    if (bad) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      right_q <= 1'b0;
      left_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      right_q <= right_d;
      left_q  <= left_d;
    end
  end

`ifdef ROTARY_DECODER_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= bad;
  end

  assign err_o = err_q;
`endif

  assign right_o  = right_q;
  assign left_o   = left_q;
  assign a_filt_o = filt_q[1];
  assign b_filt_o = filt_q[0];

endmodule
`default_nettype wire

// File: tb/tb_rotary_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rotary_decoder: directed self-checking bench for rotary_decoder.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_rotary_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b1;
  logic b   = 1'b1;
  logic right_o, left_o, a_filt_o, b_filt_o;
`ifdef ROTARY_DECODER_ERR_EN
  logic err_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rotary_decoder #(
    .CLOCK_FREQ_MHZ(100),
    .DELAY_IN_US   (1)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .a_i     (a),
    .b_i     (b),
    .right_o (right_o),
    .left_o  (left_o),
    .a_filt_o(a_filt_o),
`ifdef ROTARY_DECODER_ERR_EN
    .b_filt_o(b_filt_o),
    .err_o   (err_o)
`else
    .b_filt_o(b_filt_o)
`endif
  );

  // Cumulative event counters; the test compares snapshot differences.
  int r_cnt = 0, l_cnt = 0, both_cnt = 0, e_cnt = 0;
  int at_cnt = 0, bt_cnt = 0, rst_viol = 0;
  logic a_prev = 1'b1, b_prev = 1'b1;

  always @(negedge clk) begin
    if (right_o) r_cnt++;
    if (left_o) l_cnt++;
    if (right_o && left_o) both_cnt++;
`ifdef ROTARY_DECODER_ERR_EN
    if (err_o) e_cnt++;
`endif
    if (a_filt_o != a_prev) at_cnt++;
    if (b_filt_o != b_prev) bt_cnt++;
    a_prev = a_filt_o;
    b_prev = b_filt_o;
    if (rst && (right_o || left_o || !a_filt_o || !b_filt_o)) rst_viol++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle random chatter for one debounce window, then settle on val.
  task automatic bounce(input bit on_a, input bit val);
    for (int i = 0; i < 100; i++) begin
      if (on_a) a = 1'($urandom_range(0, 1));
      else      b = 1'($urandom_range(0, 1));
      cyc(1);
    end
    if (on_a) a = val;
    else      b = val;
  endtask

  typedef struct {
    string       name;
    logic [11:0] steps;   // six {A,B} pairs, first pair in bits 11:10
    int          exp_r;
    int          exp_l;
  } vec_t;

  vec_t vecs[6];
  int r0, l0, a0, b0, e0;
  time t0, t1;
  bit seen;

  initial begin
    vecs[0] = '{"right_clean",  {2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b11}, 1, 0};
    vecs[1] = '{"left_clean",   {2'b10, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11}, 0, 1};
    vecs[2] = '{"right_rev",    {2'b01, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11}, 0, 0};
    vecs[3] = '{"left_partial", {2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11}, 0, 0};
    vecs[4] = '{"right_wobble", {2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11}, 1, 0};
    vecs[5] = '{"left_wobble",  {2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11}, 0, 1};

    // Reset hold with idle contacts.
    cyc(100);
    check("rst_right", int'(right_o), 0);
    check("rst_left", int'(left_o), 0);
    check("rst_a_filt", int'(a_filt_o), 1);
    check("rst_b_filt", int'(b_filt_o), 1);
    rst = 1'b0;
    cyc(200);
    check("post_rst_strobes", r_cnt + l_cnt, 0);

    // Table of detent shapes, 3 us per step.
    foreach (vecs[v]) begin
      r0 = r_cnt; l0 = l_cnt;
      for (int s = 0; s < 6; s++) begin
        {a, b} = vecs[v].steps[11 - 2*s -: 2];
        cyc(300);
      end
      check({vecs[v].name, "_right"}, r_cnt - r0, vecs[v].exp_r);
      check({vecs[v].name, "_left"}, l_cnt - l0, vecs[v].exp_l);
    end

    // Strobe latency from the final raw B rise.
    r0 = r_cnt;
    a = 1'b0; cyc(300);
    b = 1'b0; cyc(300);
    a = 1'b1; cyc(300);
    b = 1'b1;
    t0 = $time;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (right_o) begin
        seen = 1'b1;
        t1 = $time;
      end
    end
    if (!seen) t1 = t0;
    check_range("right_latency_ns", int'(t1 - t0), 1020, 1055);
    cyc(200);
    check("latency_right_count", r_cnt - r0, 1);

    // Bouncy left detent.
    r0 = r_cnt; l0 = l_cnt; a0 = at_cnt; b0 = bt_cnt;
    bounce(1'b0, 1'b0); cyc(200);
    bounce(1'b1, 1'b0); cyc(100);
    bounce(1'b0, 1'b1); cyc(200);
    bounce(1'b1, 1'b1); cyc(300);
    check("bounce_left", l_cnt - l0, 1);
    check("bounce_right", r_cnt - r0, 0);
    check("bounce_a_toggles", at_cnt - a0, 2);
    check("bounce_b_toggles", bt_cnt - b0, 2);

    // Short glitch on A is filtered out.
    r0 = r_cnt; l0 = l_cnt; a0 = at_cnt;
    a = 1'b0; cyc(50);
    a = 1'b1; cyc(300);
    check("glitch_a_toggles", at_cnt - a0, 0);
    check("glitch_strobes", (r_cnt - r0) + (l_cnt - l0), 0);

    // Reset while in R2, then finish the detent.
    r0 = r_cnt; l0 = l_cnt;
    a = 1'b0; cyc(300);
    b = 1'b0; cyc(300);
    rst = 1'b1;
    #2;
    check("midrst_a_filt", int'(a_filt_o), 1);
    check("midrst_b_filt", int'(b_filt_o), 1);
    cyc(10);
    rst = 1'b0;
    cyc(300);
    a = 1'b1; cyc(300);
    b = 1'b1; cyc(300);
    check("midrst_strobes", (r_cnt - r0) + (l_cnt - l0), 0);

    // Both contacts moving in the same cycle.
    r0 = r_cnt; l0 = l_cnt; e0 = e_cnt;
    {a, b} = 2'b00; cyc(300);
    {a, b} = 2'b11; cyc(300);
    check("simul_strobes", (r_cnt - r0) + (l_cnt - l0), 0);
`ifdef ROTARY_DECODER_ERR_EN
    check("simul_err_pulses", e_cnt - e0, 1);
`endif

    check("never_both_high", both_cnt, 0);
    check("reset_output_violations", rst_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rotary_decoder.md
# rotary_decoder

Front-end stage for the brightness controller. Takes the raw, bouncing quadrature contacts of a mechanical rotary encoder and synchronises and debounces each contact. It then decodes complete detent cycles into single-cycle `right_o` / `left_o` step strobes. The light manager consumes these strobes to raise or lower the PWM brightness by its increment.

## Interface

Parameters:
- `CLOCK_FREQ_MHZ`, default 100: clock frequency in MHz; legal range 1..655.
- `DELAY_IN_US`, default 1: debounce stability window in µs.
- Derived local `N = CLOCK_FREQ_MHZ * DELAY_IN_US`: debounce cycles; N ≥ 2 required.
- Derived local counter width: `$clog2(N)`.

Ports:
- `clk_i` input 1: single clock; all logic on rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `a_i` input 1: raw encoder contact A; asynchronous; idle high.
- `b_i` input 1: raw encoder contact B; asynchronous; idle high.
- `right_o` output 1: one-cycle strobe per completed clockwise detent.
- `left_o` output 1: one-cycle strobe per completed counter-clockwise detent.
- `a_filt_o` output 1: debounced A.
- `b_filt_o` output 1: debounced B.
- `err_o` output 1: illegal-transition strobe; present only with `ROTARY_DECODER_ERR_EN`.

## Operation

Synchroniser:
- Two flops per contact.
- Reset value 1.

Debouncer, one per contact:
- Counter clears whenever the synchronised value equals the filtered value.
- Otherwise the counter increments each cycle.
- After N consecutive differing cycles: filtered ← synchronised, counter ← 0.
- Any intermediate agreement restarts the window.
- Filtered value resets to 1.

Decoder FSM on the pair (A,B), filtered. States: IDLE, R1, R2, R3, L1, L2, L3. Reset → IDLE.
- IDLE: 01 → R1; 10 → L1; 00 → IDLE + error.
- R1: 00 → R2; 11 → IDLE.
- R2: 10 → R3; 01 → R1; 11 → IDLE + error.
- R3: 11 → IDLE, pulse `right_o`; 00 → R2; 01 → IDLE + error.
- L1: 00 → L2; 11 → IDLE.
- L2: 01 → L3; 10 → L1; 11 → IDLE + error.
- L3: 11 → IDLE, pulse `left_o`; 00 → L2; 10 → IDLE + error.
- Any unchanged pair: stay in the current state.
- A direction reversal mid-detent backtracks through the states, so a partial or reversed detent emits no strobe.

Outputs:
- All outputs are registered.
- `right_o` and `left_o` are never high together.
- Each is high for exactly one cycle per detent.

## Timing

- Raw contact stable at new value from cycle t → filtered changes at t+2+N (±1 for metastability resolution).
- Strobe is high in the cycle after the filtered pair becomes 11 from R3/L3.
- Worst case from last raw edge: N+4 cycles.
- Since only one filtered bit updates per cycle per contact, simultaneous updates of both bits can only occur if both raw contacts moved together. That case is treated as illegal per the table.
- Reset asserted mid-detent:
  - outputs drop immediately to 0 (filtered to 1);
  - FSM → IDLE;
  - counters → 0;
  - a detent in progress is lost;
  - no strobe on release.
- Reset release: the first strobe requires a fresh full detent.
- Strobe rate: bounded by the debounce window; at most one strobe per 4N cycles.

## Configuration

`ROTARY_DECODER_ERR_EN`:
- Defined:
  - `err_o` port exists;
  - pulses high one cycle, registered, on every "+ error" transition;
  - reset value 0.
- Undefined:
  - `err_o` port absent;
  - FSM transitions identical;
  - errors silently return to IDLE.

## Test plan

Bench uses CLOCK_FREQ_MHZ=100, DELAY_IN_US=1 (N=100), 10 ns clock.

- Reset held 1 µs, contacts high → `right_o`=`left_o`=0, `a_filt_o`=`b_filt_o`=1 throughout; no strobe after release.
- Clean right detent (A falls at 0 µs, B falls at 3 µs, A rises at 6 µs, B rises at 9 µs) → exactly one 10 ns `right_o` pulse 1.02–1.05 µs after B rises; `left_o` stays 0.
- Left detent with 1 µs of random per-cycle bounce on each edge (B first, A 3 µs later, each low 5 µs) → exactly one `left_o` pulse; `a_filt_o`/`b_filt_o` each toggle exactly twice.
- Glitch: A low for 0.5 µs then high → `a_filt_o` never changes, no strobes.
- Reversal: sequence 11→01→00→01→11 at 3 µs spacing → no strobe. A second case asserts reset while in R2 → FSM IDLE, no strobe after completing the remaining edges.
- With `ROTARY_DECODER_ERR_EN`: A and B fall in the same cycle → one `err_o` pulse ~1.02 µs later, FSM IDLE, no direction strobe. Without the macro, the same stimulus → no strobe.
